com_tx_queue: RTL

//  Transmit-side front end for com_mod: buffers bytes from game logic (move/

---
 rtl/com_tx_queue_pkg.sv | 17 +
 rtl/com_tx_queue_if.sv | 24 ++
 rtl/com_tx_fifo.sv | 78 +++++++
 rtl/com_tx_queue.sv | 138 +++++++++++++
 4 files changed

// File: rtl/com_tx_queue_pkg.sv
// Shared definitions for the com_mod transmit path: FSM state encoding and
// default sizing constants, also intended for the future receive side.
package com_tx_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ADDR_W     = 3;
    localparam int DEF_GAP_CYCLES = 16;
    localparam int DEF_TIMEOUT    = 8192;

endpackage

// File: rtl/com_tx_queue_if.sv
// Parallel load/transmit handshake between the tx queue (master) and com_mod
// (slave).
interface com_tx_queue_if;

    logic [7:0] P_data_in;
    logic       load;
    logic       transmit_enable;
    logic       char_sent;

    modport master (
        output P_data_in,
        output load,
        output transmit_enable,
        input  char_sent
    );

    modport slave (
        input  P_data_in,
        input  load,
        input  transmit_enable,
        output char_sent
    );

endinterface

// File: rtl/com_tx_fifo.sv
// Byte FIFO feeding the com_mod transmitter: storage, wrapping pointers,
// registered count/full/empty and a sticky overflow flag.
module com_tx_fifo
    import com_tx_queue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_wr;
    logic              do_rd;
    logic              drop;
    logic [ADDR_W:0]   count_nx;

    // A full queue still takes a write when the head leaves in the same cycle.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign drop    = wr_en && !do_wr;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        if (do_wr && !do_rd) begin
            count_nx = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_nx = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nx;
            full  <= (int'(count_nx) == DEPTH);
            empty <= (count_nx == '0);
            // A fresh drop beats a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/com_tx_queue.sv
// Transmit-side front end for com_mod: queues game bytes and feeds them one
// at a time through the load/transmit_enable/char_sent handshake.
module com_tx_queue
    import com_tx_queue_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    input  logic             clr_err,
    com_tx_queue_if.master   tx,
    output logic             full,
    output logic             empty,
    output logic [ADDR_W:0]  count,
    output logic             busy,
    output logic             overflow,
    output logic             tx_timeout
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [7:0]    head;
    logic [7:0]    data_q;
    logic [7:0]    data_nx;
    logic          load_q;
    logic          load_nx;
    logic          te_q;
    logic          te_nx;
    logic          pop;
    logic          timeout_set;
    logic          timeout_hit;
    logic          gap_done;

    com_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (pop),
        .clr_err  (clr_err),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);
    assign gap_done    = (int'(cnt) == GAP_CYCLES - 1);

    assign tx.P_data_in       = data_q;
    assign tx.load            = load_q;
    assign tx.transmit_enable = te_q;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every handshake signal comes straight from a flop.
    always_comb begin
        state_nx    = state;
        data_nx     = data_q;
        load_nx     = 1'b0;
        te_nx       = 1'b0;
        pop         = 1'b0;
        timeout_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_nx = ST_LOAD;
                    load_nx  = 1'b1;
                    data_nx  = head;
                end
            end
            ST_LOAD: begin
                pop      = 1'b1;
                state_nx = ST_SEND;
                te_nx    = 1'b1;
            end
            ST_SEND: begin
                if (tx.char_sent) begin
                    state_nx = ST_GAP;
                end else if (timeout_hit) begin
                    state_nx    = ST_GAP;
                    timeout_set = 1'b1;
                end else begin
                    te_nx = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // One counter serves both the SEND watchdog and the GAP spacing; it
    // restarts on every state change.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data_q     <= '0;
            load_q     <= 1'b0;
            te_q       <= 1'b0;
            busy       <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state  <= state_nx;
            data_q <= data_nx;
            load_q <= load_nx;
            te_q   <= te_nx;
            busy   <= (state_nx != ST_IDLE);
            if (state_nx != state) begin
                cnt <= '0;
            end else if (state == ST_SEND || state == ST_GAP) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout_set) begin
                tx_timeout <= 1'b1;
            end else if (clr_err) begin
                tx_timeout <= 1'b0;
            end
        end
    end

endmodule
